ahb_gpio_master_arb: RTL and testbench

Two-port AHB-Lite master that shares the GPIO peripheral between two on-chip requesters, for example a CPU-side command FIFO and a self-test sequencer. Each requester issues single 16-bit register reads or writes through a valid/ready handshake. The block arbitrates round-robin and runs one single-beat NONSEQ transfer at a time. It returns read data and the GPIO parity-error flag to the requester that was granted.

---
 rtl/ahb_gpio_master_arb_if.sv | 59 +++++
 rtl/ahb_gpio_master_arb.sv | 149 ++++++++++++++
 tb/tb_ahb_gpio_master_arb.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_gpio_master_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_gpio_master_arb_if
//  Description : Signal bundle for the two-requester AHB-Lite GPIO master.
//                Carries both requester command/response channels and the
//                AHB-Lite master-side bus toward the GPIO slave.
//                  master modport : the arbiter/AHB master itself
//                  slave  modport : the environment (requesters + GPIO slave)
//  Revision    : 1.0  initial release
// ============================================================================
interface ahb_gpio_master_arb_if;
    // Requester 0 command / response
    logic        REQ0_VALID;
    logic        REQ0_READY;
    logic        REQ0_WRITE;
    logic [7:0]  REQ0_ADDR;
    logic [15:0] REQ0_WDATA;
    logic        RSP0_VALID;
    logic [15:0] RSP0_RDATA;
    logic        RSP0_PARERR;
    // Requester 1 command / response
    logic        REQ1_VALID;
    logic        REQ1_READY;
    logic        REQ1_WRITE;
    logic [7:0]  REQ1_ADDR;
    logic [15:0] REQ1_WDATA;
    logic        RSP1_VALID;
    logic [15:0] RSP1_RDATA;
    logic        RSP1_PARERR;
    // AHB-Lite bus
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        PARITYERR;

    modport master (
        input  REQ0_VALID, REQ0_WRITE, REQ0_ADDR, REQ0_WDATA,
        input  REQ1_VALID, REQ1_WRITE, REQ1_ADDR, REQ1_WDATA,
        input  HREADY, HRDATA, PARITYERR,
        output REQ0_READY, RSP0_VALID, RSP0_RDATA, RSP0_PARERR,
        output REQ1_READY, RSP1_VALID, RSP1_RDATA, RSP1_PARERR,
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );

    modport slave (
        output REQ0_VALID, REQ0_WRITE, REQ0_ADDR, REQ0_WDATA,
        output REQ1_VALID, REQ1_WRITE, REQ1_ADDR, REQ1_WDATA,
        output HREADY, HRDATA, PARITYERR,
        input  REQ0_READY, RSP0_VALID, RSP0_RDATA, RSP0_PARERR,
        input  REQ1_READY, RSP1_VALID, RSP1_RDATA, RSP1_PARERR,
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );
endinterface
`default_nettype wire

// File: rtl/ahb_gpio_master_arb.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_gpio_master_arb
//  Description : Round-robin arbiter + AHB-Lite master sharing the GPIO block
//                between two requesters. One single-beat NONSEQ transfer at a
//                time: IDLE -> ADDR -> DATA -> RESP -> IDLE.
//  Ports       : HCLK     clock
//                HRESETn  asynchronous active-low reset
//                bus      ahb_gpio_master_arb_if.master (requester channels
//                         and AHB-Lite master bus)
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_gpio_master_arb #(
    parameter logic [31:0] BASE_ADDR   = 32'h5300_0000,
    parameter logic        FIRST_GRANT = 1'b0
) (
    input wire HCLK,
    input wire HRESETn,
    ahb_gpio_master_arb_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_e;

    state_e      state_q,        state_d;
    logic        last_grant_q,   last_grant_d;
    logic        gnt_q,          gnt_d;
    logic        write_q,        write_d;
    logic [7:0]  addr_q,         addr_d;
    logic [15:0] wdata_q,        wdata_d;
    logic [15:0] rsp0_rdata_q,   rsp0_rdata_d;
    logic        rsp0_parerr_q,  rsp0_parerr_d;
    logic [15:0] rsp1_rdata_q,   rsp1_rdata_d;
    logic        rsp1_parerr_q,  rsp1_parerr_d;

    logic        pick1;
    logic        accept;
    logic [15:0] cap_rdata;
    logic        unused_hrdata_hi;

    assign unused_hrdata_hi = ^bus.HRDATA[31:16];

    // Requester 1 wins when it is the only one asking, or when both ask and
    // requester 0 held the previous grant.
    assign pick1  = bus.REQ1_VALID & (~bus.REQ0_VALID | ~last_grant_q);
    // READY is masked by HRESETn so no handshake is advertised during reset.
    assign accept = (state_q == IDLE) & (bus.REQ0_VALID | bus.REQ1_VALID) & HRESETn;
    assign cap_rdata = write_q ? 16'h0000 : bus.HRDATA[15:0];

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        gnt_d         = gnt_q;
        write_d       = write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rsp0_rdata_d  = rsp0_rdata_q;
        rsp0_parerr_d = rsp0_parerr_q;
        rsp1_rdata_d  = rsp1_rdata_q;
        rsp1_parerr_d = rsp1_parerr_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = ADDR;
                    gnt_d        = pick1;
                    last_grant_d = pick1;
                    write_d      = pick1 ? bus.REQ1_WRITE : bus.REQ0_WRITE;
                    addr_d       = pick1 ? bus.REQ1_ADDR  : bus.REQ0_ADDR;
                    wdata_d      = pick1 ? bus.REQ1_WDATA : bus.REQ0_WDATA;
                end
            end
            ADDR: begin
                if (bus.HREADY) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bus.HREADY) begin
                    state_d = RESP;
                    // Only the granted requester's response registers move;
                    // the other side keeps its last response.
                    if (gnt_q) begin
                        rsp1_rdata_d  = cap_rdata;
                        rsp1_parerr_d = bus.PARITYERR;
                    end else begin
                        rsp0_rdata_d  = cap_rdata;
                        rsp0_parerr_d = bus.PARITYERR;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= IDLE;
            last_grant_q  <= ~FIRST_GRANT;
            gnt_q         <= 1'b0;
            write_q       <= 1'b0;
            addr_q        <= 8'h00;
            wdata_q       <= 16'h0000;
            rsp0_rdata_q  <= 16'h0000;
            rsp0_parerr_q <= 1'b0;
            rsp1_rdata_q  <= 16'h0000;
            rsp1_parerr_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            gnt_q         <= gnt_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rsp0_rdata_q  <= rsp0_rdata_d;
            rsp0_parerr_q <= rsp0_parerr_d;
            rsp1_rdata_q  <= rsp1_rdata_d;
            rsp1_parerr_q <= rsp1_parerr_d;
        end
    end

    // Bus outputs decode from the state register alone, so the asynchronous
    // reset clears them immediately.
    assign bus.REQ0_READY  = accept & ~pick1;
    assign bus.REQ1_READY  = accept & pick1;
    assign bus.HSEL        = (state_q == ADDR);
    assign bus.HTRANS      = (state_q == ADDR) ? 2'b10 : 2'b00;
    assign bus.HADDR       = (state_q == ADDR) ? (BASE_ADDR | {24'h0, addr_q}) : 32'h0;
    assign bus.HWRITE      = (state_q == ADDR) & write_q;
    assign bus.HSIZE       = 3'b010;
    assign bus.HWDATA      = ((state_q == DATA) & write_q) ? {16'h0, wdata_q} : 32'h0;
    assign bus.RSP0_VALID  = (state_q == RESP) & ~gnt_q;
    assign bus.RSP1_VALID  = (state_q == RESP) & gnt_q;
    assign bus.RSP0_RDATA  = rsp0_rdata_q;
    assign bus.RSP0_PARERR = rsp0_parerr_q;
    assign bus.RSP1_RDATA  = rsp1_rdata_q;
    assign bus.RSP1_PARERR = rsp1_parerr_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_gpio_master_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_gpio_master_arb
//  Description : Directed self-checking bench for ahb_gpio_master_arb.
//                Inputs are driven and outputs sampled on the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ahb_gpio_master_arb;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ahb_gpio_master_arb_if bus();

    ahb_gpio_master_arb #(
        .BASE_ADDR  (32'h5300_0000),
        .FIRST_GRANT(1'b0)
    ) dut (
        .HCLK   (clk),
        .HRESETn(rst_n),
        .bus    (bus)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.REQ0_VALID = 1'b0; bus.REQ0_WRITE = 1'b0; bus.REQ0_ADDR = 8'h00; bus.REQ0_WDATA = 16'h0;
        bus.REQ1_VALID = 1'b0; bus.REQ1_WRITE = 1'b0; bus.REQ1_ADDR = 8'h00; bus.REQ1_WDATA = 16'h0;
        bus.HREADY = 1'b1; bus.HRDATA = 32'h0; bus.PARITYERR = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.REQ0_VALID = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.HSEL, bus.HTRANS, bus.HWRITE, bus.HSIZE} !== 7'b0_00_0_010) begin
            failures++; $display("FAIL rst_ctrl got=%b exp=%b", {bus.HSEL, bus.HTRANS, bus.HWRITE, bus.HSIZE}, 7'b0_00_0_010);
        end
        checks++;
        if ({bus.HADDR, bus.HWDATA} !== 64'h0) begin
            failures++; $display("FAIL rst_addr_data got=%h exp=0", {bus.HADDR, bus.HWDATA});
        end
        checks++;
        if ({bus.REQ0_READY, bus.REQ1_READY, bus.RSP0_VALID, bus.RSP1_VALID} !== 4'b0000) begin
            failures++; $display("FAIL rst_hs got=%b exp=0000", {bus.REQ0_READY, bus.REQ1_READY, bus.RSP0_VALID, bus.RSP1_VALID});
        end
        checks++;
        if ({bus.RSP0_RDATA, bus.RSP0_PARERR, bus.RSP1_RDATA, bus.RSP1_PARERR} !== 34'h0) begin
            failures++; $display("FAIL rst_rsp got=%h exp=0", {bus.RSP0_RDATA, bus.RSP0_PARERR, bus.RSP1_RDATA, bus.RSP1_PARERR});
        end
        bus.REQ0_VALID = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write0();
        bus.REQ0_VALID = 1'b1; bus.REQ0_WRITE = 1'b1; bus.REQ0_ADDR = 8'h04; bus.REQ0_WDATA = 16'h0001;
        bus.HREADY = 1'b1;
        #1;
        checks++;
        if (bus.REQ0_READY !== 1'b1) begin
            failures++; $display("FAIL wr_ready_k got=%b exp=1", bus.REQ0_READY);
        end
        tick();                         // cycle k+1: address phase
        checks++;
        if ({bus.HSEL, bus.HTRANS, bus.HWRITE, bus.HADDR} !== {1'b1, 2'b10, 1'b1, 32'h5300_0004}) begin
            failures++; $display("FAIL wr_addr_phase got=%h exp=%h", {bus.HSEL, bus.HTRANS, bus.HWRITE, bus.HADDR}, {1'b1, 2'b10, 1'b1, 32'h5300_0004});
        end
        checks++;
        if (bus.REQ0_READY !== 1'b0) begin
            failures++; $display("FAIL wr_ready_k1 got=%b exp=0", bus.REQ0_READY);
        end
        bus.REQ0_VALID = 1'b0;
        tick();                         // cycle k+2: data phase
        checks++;
        if ({bus.HSEL, bus.HTRANS, bus.HWDATA} !== {1'b0, 2'b00, 32'h0000_0001}) begin
            failures++; $display("FAIL wr_data_phase got=%h exp=%h", {bus.HSEL, bus.HTRANS, bus.HWDATA}, {1'b0, 2'b00, 32'h0000_0001});
        end
        checks++;
        if (bus.REQ0_READY !== 1'b0) begin
            failures++; $display("FAIL wr_ready_k2 got=%b exp=0", bus.REQ0_READY);
        end
        tick();                         // cycle k+3: response
        checks++;
        if ({bus.RSP0_VALID, bus.RSP1_VALID, bus.RSP0_RDATA, bus.REQ0_READY} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
            failures++; $display("FAIL wr_resp got=%h exp=%h", {bus.RSP0_VALID, bus.RSP1_VALID, bus.RSP0_RDATA, bus.REQ0_READY}, {1'b1, 1'b0, 16'h0000, 1'b0});
        end
        tick();
        checks++;
        if (bus.RSP0_VALID !== 1'b0) begin
            failures++; $display("FAIL wr_resp_width got=%b exp=0", bus.RSP0_VALID);
        end
    endtask

    task automatic test_read1();
        bus.REQ1_VALID = 1'b1; bus.REQ1_WRITE = 1'b0; bus.REQ1_ADDR = 8'h00; bus.REQ1_WDATA = 16'h0;
        bus.HRDATA = 32'h0000_A5A5; bus.PARITYERR = 1'b1; bus.HREADY = 1'b1;
        #1;
        tick();                         // k+1
        checks++;
        if ({bus.HSEL, bus.HTRANS, bus.HWRITE, bus.HADDR} !== {1'b1, 2'b10, 1'b0, 32'h5300_0000}) begin
            failures++; $display("FAIL rd_addr_phase got=%h exp=%h", {bus.HSEL, bus.HTRANS, bus.HWRITE, bus.HADDR}, {1'b1, 2'b10, 1'b0, 32'h5300_0000});
        end
        bus.REQ1_VALID = 1'b0;
        tick();                         // k+2
        checks++;
        if ({bus.HTRANS, bus.HWDATA} !== 34'h0) begin
            failures++; $display("FAIL rd_data_phase got=%h exp=0", {bus.HTRANS, bus.HWDATA});
        end
        tick();                         // k+3
        checks++;
        if ({bus.RSP1_VALID, bus.RSP1_RDATA, bus.RSP1_PARERR, bus.RSP0_VALID} !== {1'b1, 16'hA5A5, 1'b1, 1'b0}) begin
            failures++; $display("FAIL rd_resp got=%h exp=%h", {bus.RSP1_VALID, bus.RSP1_RDATA, bus.RSP1_PARERR, bus.RSP0_VALID}, {1'b1, 16'hA5A5, 1'b1, 1'b0});
        end
        bus.HRDATA = 32'h0; bus.PARITYERR = 1'b0;
        tick();
        checks++;
        if ({bus.RSP1_VALID, bus.RSP1_RDATA, bus.RSP1_PARERR} !== {1'b0, 16'hA5A5, 1'b1}) begin
            failures++; $display("FAIL rd_resp_hold got=%h exp=%h", {bus.RSP1_VALID, bus.RSP1_RDATA, bus.RSP1_PARERR}, {1'b0, 16'hA5A5, 1'b1});
        end
    endtask

    task automatic test_arb();
        int n = 0;
        int cyc = 0;
        int last_cyc = 0;
        logic exp_g;
        logic granted_now;
        logic [31:0] exp_addr;
        rst_n = 1'b0;
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        bus.REQ0_VALID = 1'b1; bus.REQ0_WRITE = 1'b1; bus.REQ0_ADDR = 8'h00; bus.REQ0_WDATA = 16'h1111;
        bus.REQ1_VALID = 1'b1; bus.REQ1_WRITE = 1'b1; bus.REQ1_ADDR = 8'h04; bus.REQ1_WDATA = 16'h2222;
        #1;
        exp_addr = 32'h0;
        while (n < 4 && cyc < 40) begin
            granted_now = 1'b0;
            if (bus.REQ0_READY || bus.REQ1_READY) begin
                exp_g = (n % 2 == 1);
                checks++;
                if ({bus.REQ1_READY, bus.REQ0_READY} !== (exp_g ? 2'b10 : 2'b01)) begin
                    failures++; $display("FAIL arb_order grant#%0d got=%b exp=%b", n, {bus.REQ1_READY, bus.REQ0_READY}, (exp_g ? 2'b10 : 2'b01));
                end
                if (n > 0) begin
                    checks++;
                    if (cyc - last_cyc != 4) begin
                        failures++; $display("FAIL arb_spacing grant#%0d got=%0d exp=4", n, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                n++;
                granted_now = 1'b1;
                exp_addr = exp_g ? 32'h5300_0004 : 32'h5300_0000;
            end
            tick();
            cyc++;
            if (granted_now) begin
                checks++;
                if (bus.HADDR !== exp_addr) begin
                    failures++; $display("FAIL arb_haddr grant#%0d got=%h exp=%h", n - 1, bus.HADDR, exp_addr);
                end
            end
        end
        checks++;
        if (n != 4) begin
            failures++; $display("FAIL arb_timeout got=%0d grants exp=4", n);
        end
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_wait();
        bus.REQ0_VALID = 1'b1; bus.REQ0_WRITE = 1'b1; bus.REQ0_ADDR = 8'h04; bus.REQ0_WDATA = 16'hBEEF;
        bus.HREADY = 1'b0;
        #1;
        tick();                         // k+1
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.HSEL, bus.HTRANS, bus.HWRITE, bus.HADDR, bus.RSP0_VALID} !== {1'b1, 2'b10, 1'b1, 32'h5300_0004, 1'b0}) begin
                failures++; $display("FAIL wait_addr cyc%0d got=%h exp=%h", i, {bus.HSEL, bus.HTRANS, bus.HWRITE, bus.HADDR, bus.RSP0_VALID}, {1'b1, 2'b10, 1'b1, 32'h5300_0004, 1'b0});
            end
            bus.REQ0_VALID = 1'b0;
            bus.HREADY = (i == 3);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bus.HSEL, bus.HTRANS, bus.HWDATA, bus.RSP0_VALID} !== {1'b0, 2'b00, 32'h0000_BEEF, 1'b0}) begin
                failures++; $display("FAIL wait_data cyc%0d got=%h exp=%h", i, {bus.HSEL, bus.HTRANS, bus.HWDATA, bus.RSP0_VALID}, {1'b0, 2'b00, 32'h0000_BEEF, 1'b0});
            end
            bus.HREADY = (i == 2);
            tick();
        end
        // Base latency of 3 cycles plus 3 address and 2 data wait states: k+8.
        checks++;
        if ({bus.RSP0_VALID, bus.RSP1_VALID, bus.RSP0_RDATA} !== {1'b1, 1'b0, 16'h0000}) begin
            failures++; $display("FAIL wait_resp got=%h exp=%h", {bus.RSP0_VALID, bus.RSP1_VALID, bus.RSP0_RDATA}, {1'b1, 1'b0, 16'h0000});
        end
        tick();
        checks++;
        if (bus.RSP0_VALID !== 1'b0) begin
            failures++; $display("FAIL wait_resp_width got=%b exp=0", bus.RSP0_VALID);
        end
    endtask

    task automatic test_reset_mid();
        bus.REQ1_VALID = 1'b1; bus.REQ1_WRITE = 1'b0; bus.REQ1_ADDR = 8'h00;
        bus.HRDATA = 32'h0000_FFFF; bus.PARITYERR = 1'b1; bus.HREADY = 1'b1;
        #1;
        tick();                         // ADDR
        bus.REQ1_VALID = 1'b0;
        tick();                         // DATA, stall it
        bus.HREADY = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.HSEL, bus.HTRANS, bus.HWRITE, bus.HADDR, bus.HWDATA, bus.HSIZE} !== {1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 3'b010}) begin
            failures++; $display("FAIL midrst_bus got=%h exp=%h", {bus.HSEL, bus.HTRANS, bus.HWRITE, bus.HADDR, bus.HWDATA, bus.HSIZE}, {1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 3'b010});
        end
        bus.HREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) rst_n = 1'b1;
            tick();
            checks++;
            if ({bus.RSP0_VALID, bus.RSP1_VALID, bus.RSP1_RDATA} !== 18'h0) begin
                failures++; $display("FAIL midrst_no_rsp cyc%0d got=%h exp=0", i, {bus.RSP0_VALID, bus.RSP1_VALID, bus.RSP1_RDATA});
            end
        end
        bus.PARITYERR = 1'b0; bus.HRDATA = 32'h0000_0042;
        bus.REQ0_VALID = 1'b1; bus.REQ0_WRITE = 1'b0; bus.REQ0_ADDR = 8'h04;
        #1;
        checks++;
        if (bus.REQ0_READY !== 1'b1) begin
            failures++; $display("FAIL midrst_ready got=%b exp=1", bus.REQ0_READY);
        end
        tick();
        checks++;
        if ({bus.HTRANS, bus.HWRITE, bus.HADDR} !== {2'b10, 1'b0, 32'h5300_0004}) begin
            failures++; $display("FAIL midrst_addr got=%h exp=%h", {bus.HTRANS, bus.HWRITE, bus.HADDR}, {2'b10, 1'b0, 32'h5300_0004});
        end
        bus.REQ0_VALID = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.RSP0_VALID, bus.RSP1_VALID, bus.RSP0_RDATA, bus.RSP0_PARERR} !== {1'b1, 1'b0, 16'h0042, 1'b0}) begin
            failures++; $display("FAIL midrst_resp got=%h exp=%h", {bus.RSP0_VALID, bus.RSP1_VALID, bus.RSP0_RDATA, bus.RSP0_PARERR}, {1'b1, 1'b0, 16'h0042, 1'b0});
        end
        tick();
    endtask

    task automatic test_withdraw();
        int hsel_cnt = 0;
        int rsp0_cnt = 0;
        int rsp1_cnt = 0;
        bus.REQ1_VALID = 1'b1; bus.REQ1_WRITE = 1'b1; bus.REQ1_ADDR = 8'h00; bus.REQ1_WDATA = 16'h0005;
        bus.HREADY = 1'b1;
        #1;
        tick();                         // k+1
        bus.REQ1_VALID = 1'b0;
        bus.REQ0_VALID = 1'b1; bus.REQ0_WRITE = 1'b0; bus.REQ0_ADDR = 8'h04;
        #1;
        checks++;
        if (bus.REQ0_READY !== 1'b0) begin
            failures++; $display("FAIL wd_ready_addr got=%b exp=0", bus.REQ0_READY);
        end
        tick();                         // k+2, DATA for requester 1
        checks++;
        if (bus.REQ0_READY !== 1'b0) begin
            failures++; $display("FAIL wd_ready_data got=%b exp=0", bus.REQ0_READY);
        end
        bus.REQ0_VALID = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.HSEL === 1'b1) hsel_cnt++;
            if (bus.RSP0_VALID === 1'b1) rsp0_cnt++;
            if (bus.RSP1_VALID === 1'b1) rsp1_cnt++;
            tick();
        end
        checks++;
        if (hsel_cnt != 0) begin
            failures++; $display("FAIL wd_no_transfer got=%0d exp=0", hsel_cnt);
        end
        checks++;
        if ({rsp0_cnt, rsp1_cnt} != {32'd0, 32'd1}) begin
            failures++; $display("FAIL wd_rsp_count got=%0d/%0d exp=0/1", rsp0_cnt, rsp1_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write0();
        test_read1();
        test_arb();
        test_wait();
        test_reset_mid();
        test_withdraw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
